rr_grant_arbiter8: RTL and testbench

- Round-robin arbiter sharing one resource among 2**SEL_W requesters (default 8).
- Keeps a binary owner index and expands it to a one-hot grant vector with a binary-to-one-hot decoder.
- Holds a grant until the owner drops its request, or until a hold-time limit forces release.
- Sits in front of any shared datapath slot: bus port, memory bank or decoder-selected peripheral.

---
 rtl/rr_grant_arbiter8_pkg.sv | 7 +
 rtl/rr_grant_arbiter8_onehot_decode.sv | 12 +
 rtl/rr_grant_arbiter8.sv | 81 ++++++++
 tb/tb_rr_grant_arbiter8.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter8_pkg.sv
// rr_grant_arbiter8_pkg: shared state encoding and default sizing for the round-robin arbiter
package rr_grant_arbiter8_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  localparam int DEF_SEL_W    = 3;
  localparam int DEF_MAX_HOLD = 16;
  localparam int DEF_CNT_W    = 5;
endpackage

// File: rtl/rr_grant_arbiter8_onehot_decode.sv
// onehot_decode: binary index to one-hot vector, forced to zero when not enabled
module onehot_decode
  import rr_grant_arbiter8_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [SEL_W-1:0]    idx,
  input  logic                en,
  output logic [2**SEL_W-1:0] onehot
);
  assign onehot = en ? (2**SEL_W)'(1) << idx : '0;
endmodule

// File: rtl/rr_grant_arbiter8.sv
// rr_grant_arbiter8: round-robin arbiter with hold-until-release, hold-time limit and a turnaround gap
module rr_grant_arbiter8
  import rr_grant_arbiter8_pkg::*;
#(
  parameter int SEL_W    = DEF_SEL_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2**SEL_W-1:0] req,
  output logic [2**SEL_W-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_valid,
  output logic                timeout
);
  localparam int N = 2**SEL_W;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  state_e state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d, last_q, last_d, win, cand;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic to_q, to_d, found;
  // scan starts just after the previous owner, so the previous owner is examined last
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = last_q + SEL_W'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = BUSY;
        idx_d   = win;
        last_d  = win;
        hold_d  = '0;
      end
    end else if (!req[idx_q]) begin
      state_d = IDLE;
    end else if (MAX_HOLD != 0 && hold_q == LIMIT) begin
      state_d = IDLE;
      to_d    = 1'b1;
    end else begin
      hold_d = (&hold_q) ? hold_q : hold_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '1;
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end
  assign grant_valid = (state_q == BUSY);
  assign grant_idx   = idx_q;
  assign timeout     = to_q;
  onehot_decode #(.SEL_W(SEL_W)) u_dec (
    .idx   (idx_q),
    .en    (grant_valid),
    .onehot(grant)
  );
endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// tb_rr_grant_arbiter8: table vectors, directed corner sequences and a randomized reference-model run
module tb_rr_grant_arbiter8;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] req4 = '0, req0 = '0;
  logic [7:0] grant4, grant0;
  logic [2:0] idx4, idx0;
  logic valid4, valid0, to4, to0;
  int tests = 0, fails = 0;
  rr_grant_arbiter8 #(.SEL_W(3), .MAX_HOLD(4), .CNT_W(5)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .grant(grant4), .grant_idx(idx4),
    .grant_valid(valid4), .timeout(to4));
  rr_grant_arbiter8 #(.SEL_W(3), .MAX_HOLD(0), .CNT_W(5)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .grant(grant0), .grant_idx(idx0),
    .grant_valid(valid0), .timeout(to0));
  always #5 clk = ~clk;
  // reference model of the MAX_HOLD=4 instance, stepped once per rising edge
  bit m_busy, m_to;
  int m_owner, m_last, m_hold;
  function automatic int pick(int last, logic [7:0] r);
    for (int k = 1; k <= 8; k++)
      if (r[(last + k) % 8]) return (last + k) % 8;
    return -1;
  endfunction
  task automatic model_reset();
    m_busy = 0; m_to = 0; m_owner = 0; m_last = 7; m_hold = 0;
  endtask
  task automatic model_step(input logic [7:0] r);
    int w;
    if (!m_busy) begin
      m_to = 0;
      w = pick(m_last, r);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_last = w; m_hold = 0;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0; m_to = 0;
    end else if (m_hold == 3) begin
      m_busy = 0; m_to = 1;
    end else begin
      m_hold++; m_to = 0;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input logic [7:0] r);
    @(negedge clk);
    req4 = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask
  task automatic check_model(input string tag);
    chk({tag, " grant"}, {24'b0, grant4}, m_busy ? 32'(1) << m_owner : 32'h0);
    chk({tag, " valid"}, {31'b0, valid4}, {31'b0, m_busy});
    chk({tag, " timeout"}, {31'b0, to4}, {31'b0, m_to});
    if (m_busy) chk({tag, " idx"}, {29'b0, idx4}, 32'(m_owner));
    chk({tag, " onehot"}, {31'b0, ($countones(grant4) <= 1) && (valid4 == |grant4)}, 32'h1);
  endtask
  task automatic do_reset();
    rst = 1'b1; req4 = '0; req0 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  typedef struct {
    logic [7:0] req;
    logic [7:0] g;
    logic [2:0] idx;
    logic       v;
    logic       to;
  } vec_t;
  vec_t tbl[8];
  initial begin
    tbl[0] = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[1] = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[2] = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 3'd7, 1'b0, 1'b0};
    tbl[6] = '{8'h84, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[7] = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
    do_reset();
    #1;
    chk("reset grant", {24'b0, grant4}, 32'h0);
    chk("reset valid", {31'b0, valid4}, 32'h0);
    chk("reset timeout", {31'b0, to4}, 32'h0);
    chk("reset idx", {29'b0, idx4}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].req);
      chk($sformatf("tbl%0d grant", i), {24'b0, grant4}, {24'b0, tbl[i].g});
      chk($sformatf("tbl%0d valid", i), {31'b0, valid4}, {31'b0, tbl[i].v});
      chk($sformatf("tbl%0d timeout", i), {31'b0, to4}, {31'b0, tbl[i].to});
      if (tbl[i].v) chk($sformatf("tbl%0d idx", i), {29'b0, idx4}, {29'b0, tbl[i].idx});
    end
    // fairness under continuous contention: 4-cycle grants, one idle gap, alternating owners
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      tick(8'h81);
      chk($sformatf("fair c%0d grant", c), {24'b0, grant4},
          ((c - 1) % 5 == 4) ? 32'h0 : ((((c - 1) / 5) % 2 == 0) ? 32'h01 : 32'h80));
      chk($sformatf("fair c%0d timeout", c), {31'b0, to4}, ((c - 1) % 5 == 4) ? 32'h1 : 32'h0);
      check_model("fair");
    end
    // owner drops request exactly when the hold limit is reached
    do_reset();
    repeat (4) tick(8'h01);
    chk("limit hold grant", {24'b0, grant4}, 32'h01);
    tick(8'h00);
    chk("limit release grant", {24'b0, grant4}, 32'h0);
    chk("limit release timeout", {31'b0, to4}, 32'h0);
    tick(8'h00);
    chk("limit after timeout", {31'b0, to4}, 32'h0);
    // asynchronous reset while busy
    do_reset();
    tick(8'h10);
    chk("async pre grant", {24'b0, grant4}, 32'h10);
    #1 rst = 1'b1;
    #1;
    chk("async grant", {24'b0, grant4}, 32'h0);
    chk("async valid", {31'b0, valid4}, 32'h0);
    #1 rst = 1'b0;
    model_reset();
    tick(8'hFF);
    chk("async next winner", {24'b0, grant4}, 32'h01);
    chk("async next idx", {29'b0, idx4}, 32'h0);
    // timeout disabled: grant held indefinitely
    do_reset();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      req0 = 8'h02;
      @(posedge clk);
      #1;
      chk("nohold grant", {24'b0, grant0}, 32'h02);
      chk("nohold timeout", {31'b0, to0}, 32'h0);
      chk("nohold onehot", {31'b0, ($countones(grant0) <= 1) && (valid0 == |grant0)}, 32'h1);
    end
    req0 = '0;
    // randomized traffic, biased so the owner often keeps requesting
    do_reset();
    for (int c = 0; c < 500; c++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if (m_busy && ($urandom_range(0, 3) != 0)) r[m_owner] = 1'b1;
      if ($urandom_range(0, 7) == 0) r = '0;
      tick(r);
      check_model("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
